hls_run_sequencer: RTL and testbench
====================================

# hls_run_sequencer

Host-side sequencer for one Bambu-generated `main` accelerator instance.
- Accepts serialized commands (memory write, memory read, run) and translates them into accelerator slave-RAM transactions and a start/done run.
- Measures run latency in clock cycles, with memory-wait and run watchdogs.
- Sits between the host/debug bus and the accelerator. Replaces the free-running testbench control loop in on-chip measurement builds.

## Interface

Parameters:
- ADDR_W, 8: per-channel slave address width.
- DATA_W, 64: per-channel slave data width.
- SIZE_W, 7: per-channel data-size field width, in bits.
- CYC_W, 32: cycle counter width.
- RUN_TIMEOUT, 200000000: run watchdog limit, in cycles.
- MEM_TIMEOUT, 16: memory-wait watchdog limit, in cycles.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both valid and ready are high
- cmd_op  in  2  00 write, 01 read, 10 run, 11 illegal
- cmd_addr  in  ADDR_W  slave address
- cmd_wdata  in  DATA_W  write data
- cmd_size  in  SIZE_W  access size in bits
- rsp_valid  out  1  response pending
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_W  read data, or cycle count zero-extended
- rsp_status  out  2  00 ok, 01 timeout, 10 illegal op
- busy  out  1  high whenever state ≠ IDLE
- start_port  out  1  accelerator start
- done_port  in  1  accelerator done
- S_oe_ram  out  2  per-channel read enable
- S_we_ram  out  2  per-channel write enable
- S_addr_ram  out  2*ADDR_W  per-channel address
- S_Wdata_ram  out  2*DATA_W  per-channel write data
- S_data_ram_size  out  2*SIZE_W  per-channel size
- Sout_Rdata_ram  in  2*DATA_W  per-channel read data
- Sout_DataRdy  in  2  per-channel data ready

## Operation

- Only channel 0 is used. Channel-1 slices of every S_* output are tied to 0. Sout_*[1] is ignored.
- State machine states: IDLE, MEM_WR, MEM_RD, START, RUN, RESP.
- IDLE:
  - cmd_ready = 1.
  - On accept, write → MEM_WR, read → MEM_RD, run → START.
  - On accept of illegal op 11 → RESP with status 10 and data 0.
- MEM_WR: S_we_ram[0] = 1, and addr, wdata and size are driven from the registered command. Exit on Sout_DataRdy[0] → RESP with status 00 and data 0.
- MEM_RD: S_oe_ram[0] = 1. Exit on Sout_DataRdy[0]: capture Sout_Rdata_ram[DATA_W-1:0] into rsp_data → RESP with status 00.
- Memory watchdog: a counter is cleared on entry to MEM_WR/MEM_RD. When it reaches MEM_TIMEOUT with no DataRdy → RESP with status 01, data 0, and the enables drop.
- START:
  - start_port = 1 for exactly one cycle.
  - Cycle counter is cleared to 0.
  - Next state is RUN.
- RUN:
  - The counter increments every cycle, including the cycle done_port is sampled high.
  - done_port = 1 → RESP with status 00 and rsp_data = count.
  - count == RUN_TIMEOUT → RESP with status 01 and rsp_data = count.
  - The counter saturates at all-ones and never wraps.
- RESP:
  - rsp_valid = 1, with rsp_data and rsp_status held stable.
  - rsp_valid && rsp_ready → IDLE.
- done_port high in any state other than RUN is ignored.
- DataRdy high outside MEM_WR/MEM_RD is ignored.

## Timing

- Reset value of every output is 0: cmd_ready, rsp_valid, rsp_data, rsp_status, busy, start_port and all S_* outputs.
- cmd_ready rises in the first cycle after reset deasserts.
- All outputs are registered.
- Slave enables assert in the cycle after command accept and deassert in the cycle after DataRdy[0] is sampled.
- Run latency:
  - start_port is high in the cycle after accept.
  - If done_port is first sampled high N cycles after the start_port cycle, then rsp_data = N and rsp_valid rises in the next cycle.
- Read latency: rsp_valid rises one cycle after DataRdy[0] is sampled.
- DataRdy and done_port sampled in the same cycle as a watchdog limit is reached: success wins, status 00.
- Reset mid-operation: asynchronously returns to IDLE. All outputs clear, counters clear, and any pending response is discarded.
- Back-to-back commands: the next command is accepted no earlier than the cycle after the RESP handshake.

## Structure

- Package hls_seq_pkg holds:
  - op codes (OP_WR, OP_RD, OP_RUN)
  - status codes (ST_OK, ST_TIMEOUT, ST_ILLEGAL)
  - the state enum
- Sub-module hls_cycle_watchdog: a CYC_W-bit clear/enable saturating counter with a limit-reached flag. It is instantiated twice, once for the run watchdog and once for the memory watchdog.

## Test plan

- Write then read: write addr 0x10, data 0xDEADBEEF, size 32, with DataRdy 1 cycle after we → status 00. Read addr 0x10 with DataRdy 2 cycles after oe and Rdata 0xDEADBEEF → rsp_data 0xDEADBEEF, status 00.
- Run: done_port asserted 3 cycles after the start pulse → start_port high exactly 1 cycle, rsp_data 3, status 00.
- Run timeout with RUN_TIMEOUT = 20 and done never asserted → rsp_data 20, status 01, busy falls after the handshake.
- Memory timeout with MEM_TIMEOUT = 16 and DataRdy never asserted → we drops, status 01. Illegal op 11 → status 10 in the cycle after accept.
- Backpressure and spurious done: hold rsp_ready = 0 for 5 cycles → rsp_valid and rsp_data stable, cmd_ready 0. done_port pulsed while in IDLE → no state change.
- Reset asserted mid-RUN → all outputs 0 immediately. A new run command after reset measures from 0.

Source files
------------

// File: rtl/hls_seq_pkg.sv
// Shared op codes, response status codes and sequencer state encoding
// for the Bambu accelerator host-side run sequencer.
package hls_seq_pkg;

   localparam logic [1:0] OP_WR  = 2'b00;
   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_RUN = 2'b10;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ILLEGAL = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MEM_WR = 3'd1,
      S_MEM_RD = 3'd2,
      S_START  = 3'd3,
      S_RUN    = 3'd4,
      S_RESP   = 3'd5
   } seq_state_e;

endpackage

// File: rtl/hls_cycle_watchdog.sv
// Clear/enable saturating cycle counter. count_next is the value the counter
// takes at the coming edge; limit_hit flags that value reaching LIMIT.
module hls_cycle_watchdog #(
   parameter int          CYC_W = 32,
   parameter int unsigned LIMIT = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CYC_W-1:0] count_next,
   output logic             limit_hit
);

   logic [CYC_W-1:0] count;

   always_comb begin
      count_next = count;
      if (clear)
         count_next = '0;
      else if (enable && (count != '1))
         count_next = count + CYC_W'(1);
   end

   assign limit_hit = enable && !clear && (count_next == CYC_W'(LIMIT));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else
         count <= count_next;
   end

endmodule

// File: rtl/hls_run_sequencer.sv
// Host-side sequencer: turns serialized write/read/run commands into slave-RAM
// transactions on channel 0 and a timed start/done run of the accelerator.
module hls_run_sequencer
   import hls_seq_pkg::*;
#(
   parameter int          ADDR_W      = 8,
   parameter int          DATA_W      = 64,
   parameter int          SIZE_W      = 7,
   parameter int          CYC_W       = 32,
   parameter int unsigned RUN_TIMEOUT = 200000000,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [SIZE_W-1:0]     cmd_size,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_data,
   output logic [1:0]            rsp_status,
   output logic                  busy,
   output logic                  start_port,
   input  logic                  done_port,
   output logic [1:0]            S_oe_ram,
   output logic [1:0]            S_we_ram,
   output logic [2*ADDR_W-1:0]   S_addr_ram,
   output logic [2*DATA_W-1:0]   S_Wdata_ram,
   output logic [2*SIZE_W-1:0]   S_data_ram_size,
   input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
   input  logic [1:0]            Sout_DataRdy
);

   localparam logic [2:0] IDLE   = S_IDLE;
   localparam logic [2:0] MEM_WR = S_MEM_WR;
   localparam logic [2:0] MEM_RD = S_MEM_RD;
   localparam logic [2:0] START  = S_START;
   localparam logic [2:0] RUN    = S_RUN;
   localparam logic [2:0] RESP   = S_RESP;

   logic [2:0]        state, state_nxt;
   logic [DATA_W-1:0] rsp_data_nxt;
   logic [1:0]        rsp_status_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [SIZE_W-1:0] size_q;
   logic              we_q, oe_q;
   logic              accept;
   logic              in_mem;
   logic [CYC_W-1:0]  run_count_next, mem_count_unused;
   logic              run_hit, mem_hit;
   logic              unused_ch1;

   // Both channels transfer only on a cycle where valid and ready are high
   // together; valid never depends on ready, and payloads are held until then.
   assign accept = cmd_valid && cmd_ready;
   assign in_mem = (state == MEM_WR) || (state == MEM_RD);

   hls_cycle_watchdog #(.CYC_W(CYC_W), .LIMIT(RUN_TIMEOUT)) u_run_wd (
      .clock      (clock),
      .reset      (reset),
      .clear      (state == START),
      .enable     (state == RUN),
      .count_next (run_count_next),
      .limit_hit  (run_hit)
   );

   hls_cycle_watchdog #(.CYC_W(CYC_W), .LIMIT(MEM_TIMEOUT)) u_mem_wd (
      .clock      (clock),
      .reset      (reset),
      .clear      (accept),
      .enable     (in_mem),
      .count_next (mem_count_unused),
      .limit_hit  (mem_hit)
   );

   always_comb begin
      state_nxt      = state;
      rsp_data_nxt   = rsp_data;
      rsp_status_nxt = rsp_status;
      case (state)
         IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_WR:   state_nxt = MEM_WR;
                  OP_RD:   state_nxt = MEM_RD;
                  OP_RUN:  state_nxt = START;
                  default: begin
                     state_nxt      = RESP;
                     rsp_status_nxt = ST_ILLEGAL;
                     rsp_data_nxt   = '0;
                  end
               endcase
            end
         end
         MEM_WR, MEM_RD: begin
            // A completion in the same cycle as the limit still counts as success.
            if (Sout_DataRdy[0]) begin
               state_nxt      = RESP;
               rsp_status_nxt = ST_OK;
               rsp_data_nxt   = (state == MEM_RD) ? Sout_Rdata_ram[DATA_W-1:0] : '0;
            end else if (mem_hit) begin
               state_nxt      = RESP;
               rsp_status_nxt = ST_TIMEOUT;
               rsp_data_nxt   = '0;
            end
         end
         START: state_nxt = RUN;
         RUN: begin
            if (done_port) begin
               state_nxt      = RESP;
               rsp_status_nxt = ST_OK;
               rsp_data_nxt   = DATA_W'(run_count_next);
            end else if (run_hit) begin
               state_nxt      = RESP;
               rsp_status_nxt = ST_TIMEOUT;
               rsp_data_nxt   = DATA_W'(run_count_next);
            end
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Every output is a register decoded from the next state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cmd_ready  <= 1'b0;
         busy       <= 1'b0;
         start_port <= 1'b0;
         we_q       <= 1'b0;
         oe_q       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_status <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= '0;
      end else begin
         state      <= state_nxt;
         cmd_ready  <= (state_nxt == IDLE);
         busy       <= (state_nxt != IDLE);
         start_port <= (state_nxt == START);
         we_q       <= (state_nxt == MEM_WR);
         oe_q       <= (state_nxt == MEM_RD);
         rsp_valid  <= (state_nxt == RESP);
         rsp_data   <= rsp_data_nxt;
         rsp_status <= rsp_status_nxt;
         if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            size_q  <= cmd_size;
         end
      end
   end

   assign S_we_ram        = {1'b0, we_q};
   assign S_oe_ram        = {1'b0, oe_q};
   assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
   assign S_Wdata_ram     = {{DATA_W{1'b0}}, wdata_q};
   assign S_data_ram_size = {{SIZE_W{1'b0}}, size_q};

   assign unused_ch1 = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed plus randomized bench for hls_run_sequencer; expected responses come
// from a command-level model of memory contents, watchdog limits and run length.
module tb_hls_run_sequencer;
   import hls_seq_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 64;
   localparam int SIZE_W = 7;
   localparam int CYC_W  = 32;
   localparam int RUN_TO = 20;
   localparam int MEM_TO = 16;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                cmd_valid = 1'b0;
   logic                cmd_ready;
   logic [1:0]          cmd_op = '0;
   logic [ADDR_W-1:0]   cmd_addr = '0;
   logic [DATA_W-1:0]   cmd_wdata = '0;
   logic [SIZE_W-1:0]   cmd_size = '0;
   logic                rsp_valid;
   logic                rsp_ready = 1'b0;
   logic [DATA_W-1:0]   rsp_data;
   logic [1:0]          rsp_status;
   logic                busy;
   logic                start_port;
   logic                done_port = 1'b0;
   logic [1:0]          S_oe_ram, S_we_ram;
   logic [2*ADDR_W-1:0] S_addr_ram;
   logic [2*DATA_W-1:0] S_Wdata_ram;
   logic [2*SIZE_W-1:0] S_data_ram_size;
   logic [2*DATA_W-1:0] Sout_Rdata_ram = '0;
   logic [1:0]          Sout_DataRdy = '0;

   hls_run_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .CYC_W(CYC_W),
      .RUN_TIMEOUT(RUN_TO), .MEM_TIMEOUT(MEM_TO)
   ) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_status(rsp_status), .busy(busy), .start_port(start_port),
      .done_port(done_port), .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram),
      .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
      .S_data_ram_size(S_data_ram_size), .Sout_Rdata_ram(Sout_Rdata_ram),
      .Sout_DataRdy(Sout_DataRdy)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- scoreboard state ----------------
   int tests = 0;
   int fails = 0;
   logic [DATA_W-1:0] ref_mem   [256];
   logic [DATA_W-1:0] slave_mem [256];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_data"}, rsp_data, 0);
      check({tag, "_rsp_status"}, rsp_status, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_start"}, start_port, 0);
      check({tag, "_enables"}, {S_we_ram, S_oe_ram}, 0);
      check({tag, "_addr_size"}, {S_addr_ram, S_data_ram_size}, 0);
      check({tag, "_wdata"}, |S_Wdata_ram, 0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [SIZE_W-1:0] size);
      int w = 0;
      while (!cmd_ready && w < 50) begin
         @(negedge clock);
         w++;
      end
      check("cmd_ready_wait", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_size  = size;
      @(negedge clock);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_addr  = ADDR_W'($urandom);
      cmd_wdata = {$urandom, $urandom};
   endtask

   task automatic resp_phase(input string tag, input logic [DATA_W-1:0] exp_data,
                             input logic [1:0] exp_status, input int hold);
      check({tag, "_rsp_valid"}, rsp_valid, 1);
      check({tag, "_rsp_data"}, rsp_data, exp_data);
      check({tag, "_rsp_status"}, rsp_status, exp_status);
      check({tag, "_busy"}, busy, 1);
      for (int k = 0; k < hold; k++) begin
         done_port    = 1'($urandom);
         Sout_DataRdy = 2'($urandom);
         @(negedge clock);
         check({tag, "_hold_valid"}, rsp_valid, 1);
         check({tag, "_hold_data"}, rsp_data, exp_data);
         check({tag, "_hold_status"}, rsp_status, exp_status);
         check({tag, "_hold_cmd_ready"}, cmd_ready, 0);
      end
      done_port    = 1'b0;
      Sout_DataRdy = '0;
      rsp_ready    = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      check({tag, "_post_valid"}, rsp_valid, 0);
      check({tag, "_post_busy"}, busy, 0);
      check({tag, "_post_cmd_ready"}, cmd_ready, 1);
   endtask

   // delay = enabled cycle (1-based) in which DataRdy is raised; 0 = never.
   task automatic do_mem(input bit is_rd, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic [SIZE_W-1:0] size,
                         input int delay, input int hold);
      bit ok = (delay >= 1) && (delay <= MEM_TO);
      int exp_en = ok ? delay : MEM_TO;
      int en_cycles = 0;
      logic en;
      logic [DATA_W-1:0] exp_data;
      send_cmd(is_rd ? OP_RD : OP_WR, addr, data, size);
      for (int j = 1; j <= 40; j++) begin
         en = is_rd ? S_oe_ram[0] : S_we_ram[0];
         if (!en) break;
         en_cycles++;
         if (j == 1) begin
            check("mem_addr", S_addr_ram, {8'h00, addr});
            check("mem_size", S_data_ram_size, {7'h00, size});
            check("mem_other_en", is_rd ? S_we_ram : S_oe_ram, 0);
            check("mem_ch1_en", {S_we_ram[1], S_oe_ram[1]}, 0);
            if (!is_rd) check("mem_wdata", S_Wdata_ram[DATA_W-1:0], data);
         end
         Sout_DataRdy   = {1'($urandom), 1'(j == delay)};
         Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
         done_port      = 1'($urandom);
         if (j == delay) begin
            if (is_rd)
               Sout_Rdata_ram[DATA_W-1:0] = slave_mem[S_addr_ram[ADDR_W-1:0]];
            else
               slave_mem[S_addr_ram[ADDR_W-1:0]] = S_Wdata_ram[DATA_W-1:0];
         end
         @(negedge clock);
      end
      Sout_DataRdy = '0;
      done_port    = 1'b0;
      check(is_rd ? "rd_oe_cycles" : "wr_we_cycles", en_cycles, exp_en);
      exp_data = (is_rd && ok) ? ref_mem[addr] : '0;
      if (!is_rd && ok) ref_mem[addr] = data;
      resp_phase(is_rd ? "rd" : "wr", exp_data, ok ? ST_OK : ST_TIMEOUT, hold);
   endtask

   // n_done = cycles after the start_port cycle at which done is high; 0 = never.
   task automatic do_run(input int n_done, input int hold);
      int lat = 0;
      int extra_start = 0;
      int exp_n = (n_done >= 1 && n_done <= RUN_TO) ? n_done : RUN_TO;
      send_cmd(OP_RUN, ADDR_W'($urandom), {$urandom, $urandom}, SIZE_W'($urandom));
      check("run_start_hi", start_port, 1);
      check("run_busy", busy, 1);
      for (int n = 1; n <= 100; n++) begin
         Sout_DataRdy = 2'($urandom);
         @(negedge clock);
         if (start_port) extra_start++;
         if (rsp_valid) begin
            lat = n;
            break;
         end
         done_port = 1'(n == n_done);
      end
      done_port    = 1'b0;
      Sout_DataRdy = '0;
      check("run_start_width", extra_start, 0);
      check("run_latency", lat, exp_n + 1);
      resp_phase("run", 64'(exp_n), (n_done >= 1 && n_done <= RUN_TO) ? ST_OK : ST_TIMEOUT, hold);
   endtask

   task automatic do_illegal(input int hold);
      send_cmd(2'b11, ADDR_W'($urandom), {$urandom, $urandom}, SIZE_W'($urandom));
      resp_phase("illegal", '0, ST_ILLEGAL, hold);
   endtask

   // ---------------- directed and random steps ----------------
   initial begin
      for (int i = 0; i < 256; i++) begin
         ref_mem[i]   = '0;
         slave_mem[i] = '0;
      end

      #1;
      check_all_zero("reset");
      repeat (3) @(negedge clock);
      check_all_zero("reset_held");
      reset = 1'b0;
      @(negedge clock);
      check("reset_release_ready", cmd_ready, 1);
      check("reset_release_busy", busy, 0);

      do_mem(1'b0, 8'h10, 64'hDEADBEEF, 7'd32, 1, 0);
      do_mem(1'b1, 8'h10, '0, 7'd32, 2, 0);
      do_run(3, 0);
      do_run(0, 0);
      do_mem(1'b0, 8'h20, 64'h0123_4567_89AB_CDEF, 7'd64, 0, 0);
      do_illegal(0);
      do_run(5, 5);

      for (int i = 0; i < 4; i++) begin
         done_port    = 1'b1;
         Sout_DataRdy = 2'b11;
         @(negedge clock);
         done_port    = 1'b0;
         Sout_DataRdy = '0;
         check("idle_spurious_busy", busy, 0);
         check("idle_spurious_ready", cmd_ready, 1);
         check("idle_spurious_valid", {rsp_valid, start_port}, 0);
      end

      do_run(RUN_TO, 1);
      do_mem(1'b0, 8'h11, 64'hCAFE_F00D, 7'd32, MEM_TO, 0);
      do_mem(1'b1, 8'h11, '0, 7'd32, MEM_TO, 0);
      do_mem(1'b1, 8'h10, '0, 7'd32, MEM_TO + 1, 0);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 4))
            0:       do_mem(1'b0, 8'h10 + 8'($urandom_range(0, 7)), {$urandom, $urandom},
                            7'($urandom_range(1, 64)), $urandom_range(0, 20), $urandom_range(0, 3));
            1, 2:    do_mem(1'b1, 8'h10 + 8'($urandom_range(0, 7)), '0,
                            7'($urandom_range(1, 64)), $urandom_range(0, 20), $urandom_range(0, 3));
            3:       do_run($urandom_range(0, 24), $urandom_range(0, 3));
            default: do_illegal($urandom_range(0, 2));
         endcase
      end

      send_cmd(OP_RUN, '0, '0, '0);
      repeat (4) @(negedge clock);
      check("pre_reset_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      check_all_zero("midrun_reset");
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("midrun_release_ready", cmd_ready, 1);
      do_run(3, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
